hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Hazard controller for the 5-stage MIPS pipeline; sequences the ID/EX boundary.
- Detects load-use hazards between the instruction in decode and the load in execute. Freezes PC and IF/ID and injects bubbles into ID/EX.
- Squashes wrong-path instructions when a branch resolves taken.
- Keeps saturating stall/flush event counters for debug.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 3, cycles IF/ID and ID/EX are squashed after a taken branch (1..7)
CNT_W, 16, width of event counters

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode stage holds a real instruction
id_rs  input  5  rs field of decode instruction
id_rt  input  5  rt field of decode instruction
id_uses_rt  input  1  decode instruction reads rt (R-type, store, branch)
ex_mem_read  input  1  ID/EX register holds a load
ex_dest  input  5  destination register of the ID/EX instruction (after reg_dest select)
br_resolve  input  1  a branch outcome is valid this cycle
br_taken  input  1  resolved branch is taken (qualified by br_resolve)
pc_write  output  1  PC register enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  clear IF/ID to NOP
idex_bubble  output  1  zero all control bits entering ID/EX
busy  output  1  FSM not in RUN
stall_events  output  CNT_W  count of load-use hazards detected, saturating
flush_events  output  CNT_W  count of taken-branch flushes, saturating

Behaviour:
- Reset (async, rst_n=0): state=RUN, counter=0, stall_events=0, flush_events=0. Combinational outputs are driven from reset state: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, busy=0.
- Hazard term: hz = id_valid & ex_mem_read & (ex_dest!=0) & ((ex_dest==id_rs) | (id_uses_rt & ex_dest==id_rt)). Register 0 never causes a hazard.
- Branch term: bt = br_resolve & br_taken.
- FSM states: RUN, STALL, FLUSH. 3-bit down-counter cnt.
- RUN:
  - If bt: ifid_flush=1 and idex_bubble=1 this cycle; pc_write=1 so the target loads. flush_events+1.
    - FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1.
    - FLUSH_CYCLES=1: stay in RUN.
  - Else if hz: pc_write=0, ifid_write=0, idex_bubble=1 this cycle. stall_events+1.
    - LOAD_STALL_CYCLES>1: go to STALL with cnt=LOAD_STALL_CYCLES-1.
    - LOAD_STALL_CYCLES=1: stay in RUN.
  - Else: all enables 1, no flush, no bubble.
- STALL: pc_write=0, ifid_write=0, idex_bubble=1. Decrement cnt; go to RUN when cnt reaches 1 at the clock edge. hz is not re-evaluated and is not counted again.
- FLUSH: ifid_flush=1, idex_bubble=1, pc_write=1. Decrement cnt; go to RUN when cnt reaches 1.
- Priority:
  - bt beats hz in RUN; the hazard instruction is wrong-path and is discarded.
  - bt during STALL aborts the stall: go to FLUSH, or to RUN if FLUSH_CYCLES=1. ifid_flush=1 and pc_write=1 that cycle. flush_events+1.
  - bt during FLUSH restarts cnt=FLUSH_CYCLES-1. flush_events+1.
- Counters saturate at all-ones and do not wrap.
- busy = (state!=RUN).
- Reset asserted mid-STALL or mid-FLUSH returns to RUN immediately and drops all stall/flush outputs asynchronously.
- Latency: hazard response is combinational in the same cycle. State and counter updates are registered on the rising clk edge.

Test Plan:
- Load-use on rs: ex_mem_read=1, ex_dest=5, id_valid=1, id_rs=5, defaults -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle (ex_mem_read=0) all enables 1. stall_events=1.
- rt gating: ex_dest=7, id_rt=7, id_uses_rt=0 -> no stall. Same with id_uses_rt=1 -> stall. ex_dest=0, id_rs=0 -> no stall.
- Taken branch, FLUSH_CYCLES=3: br_resolve=1, br_taken=1 for one cycle -> ifid_flush=1 and idex_bubble=1 for 3 consecutive cycles, busy=1 for cycles 2-3, pc_write=1 throughout. flush_events=1.
- Simultaneous hz and bt: ifid_flush=1, pc_write=1, stall_events unchanged, flush_events +1.
- LOAD_STALL_CYCLES=3, bt asserted in 2nd stall cycle -> stall aborts, enters FLUSH, pc_write=1 that cycle, flush sequence runs its full length.
- Saturation and reset: with CNT_W=4, 20 hazards -> stall_events=15. rst_n pulsed low mid-FLUSH -> outputs return to run values without a clock edge, counters=0.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller
//   Sequences the ID/EX boundary of a 5-stage MIPS pipeline. Detects load-use
//   hazards between the decode instruction and a load sitting in ID/EX, freezing
//   PC and IF/ID while bubbles enter ID/EX. A taken branch squashes the
//   wrong-path instructions in IF/ID and ID/EX for FLUSH_CYCLES cycles.
//   Saturating event counters record hazards and flushes for debug.
//
// Ports
//   clk, rst_n          pipeline clock (rising edge), async active-low reset
//   id_valid/id_rs/id_rt/id_uses_rt   decode-stage instruction fields
//   ex_mem_read/ex_dest               ID/EX instruction: load flag, dest reg
//   br_resolve/br_taken               branch outcome (taken qualified by resolve)
//   pc_write, ifid_write              PC and IF/ID enables
//   ifid_flush, idex_bubble           IF/ID clear, ID/EX control zeroing
//   busy                              sequencer not in RUN
//   stall_events, flush_events        saturating event counters
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow; hazards and taken branches handled combinationally
// STALL | remaining load-use bubble cycles; PC and IF/ID held
// FLUSH | remaining wrong-path squash cycles after a taken branch
module hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 3,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dest,
    input  logic             br_resolve,
    input  logic             br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_events,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0]       STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_events_q, stall_events_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic hz;
    logic bt;

    // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
    assign hz = id_valid & ex_mem_read & (ex_dest != 5'd0) &
                ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
    assign bt = br_resolve & br_taken;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_events_d = stall_events_q;
        flush_events_d = flush_events_q;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;

        // A taken branch wins in every state: whatever is in IF/ID and ID/EX is
        // wrong-path, and the PC must load the branch target.
        if (bt) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (flush_events_q != CNT_MAX) begin
                flush_events_d = flush_events_q + 1'b1;
            end
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (hz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (stall_events_q != CNT_MAX) begin
                            stall_events_d = stall_events_q + 1'b1;
                        end
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = STALL;
                            cnt_d   = STALL_RELOAD;
                        end
                    end
                end
                STALL: begin
                    // The hazard is already being served; it is not re-counted.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            cnt_q          <= 3'd0;
            stall_events_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_events_q <= stall_events_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign busy         = (state_q != RUN);
    assign stall_events = stall_events_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       id_uses_rt = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [4:0] ex_dest = 5'd0;
    logic       br_resolve = 1'b0;
    logic       br_taken = 1'b0;

    logic        pc_a, ifw_a, fl_a, bub_a, busy_a;
    logic [15:0] sev_a, fev_a;
    logic        pc_b, ifw_b, fl_b, bub_b, busy_b;
    logic [3:0]  sev_b, fev_b;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    hazard_controller #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .br_resolve(br_resolve), .br_taken(br_taken),
        .pc_write(pc_a), .ifid_write(ifw_a), .ifid_flush(fl_a), .idex_bubble(bub_a),
        .busy(busy_a), .stall_events(sev_a), .flush_events(fev_a)
    );

    hazard_controller #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .br_resolve(br_resolve), .br_taken(br_taken),
        .pc_write(pc_b), .ifid_write(ifw_b), .ifid_flush(fl_b), .idex_bubble(bub_b),
        .busy(busy_b), .stall_events(sev_b), .flush_events(fev_b)
    );

    // Reference model: remaining bubble/squash cycles plus event totals.
    int p_l[2]   = '{1, 3};
    int p_f[2]   = '{3, 3};
    int p_max[2] = '{65535, 15};
    int m_sl[2], m_fl[2], m_sev[2], m_fev[2];

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sl[k] = 0; m_fl[k] = 0; m_sev[k] = 0; m_fev[k] = 0;
        end
    endtask

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, busy}.
    function automatic logic [4:0] model_out(input int k, input bit hz, input bit bt);
        bit pc, ifw, fl, bub, bsy;
        pc = 1; ifw = 1; fl = 0; bub = 0;
        bsy = (m_sl[k] > 0) || (m_fl[k] > 0);
        if (bt || m_fl[k] > 0) begin
            fl = 1; bub = 1;
        end else if (m_sl[k] > 0 || hz) begin
            pc = 0; ifw = 0; bub = 1;
        end
        return {pc, ifw, fl, bub, bsy};
    endfunction

    task automatic model_step(input int k, input bit hz, input bit bt);
        if (bt) begin
            if (m_fev[k] < p_max[k]) m_fev[k]++;
            m_fl[k] = p_f[k] - 1;
            m_sl[k] = 0;
        end else if (m_fl[k] > 0) begin
            m_fl[k]--;
        end else if (m_sl[k] > 0) begin
            m_sl[k]--;
        end else if (hz) begin
            if (m_sev[k] < p_max[k]) m_sev[k]++;
            m_sl[k] = p_l[k] - 1;
        end
    endtask

    task automatic check_all(input bit hz, input bit bt);
        logic [4:0] ea, eb;
        ea = model_out(0, hz, bt);
        eb = model_out(1, hz, bt);
        chk("outs_a", int'({pc_a, ifw_a, fl_a, bub_a, busy_a}), int'(ea));
        chk("outs_b", int'({pc_b, ifw_b, fl_b, bub_b, busy_b}), int'(eb));
        chk("stall_ev_a", int'(sev_a), m_sev[0]);
        chk("flush_ev_a", int'(fev_a), m_fev[0]);
        chk("stall_ev_b", int'(sev_b), m_sev[1]);
        chk("flush_ev_b", int'(fev_b), m_fev[1]);
    endtask

    // Drive one cycle of inputs, check against the model, then clock it.
    task automatic cycle(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input bit ut, input bit mr, input logic [4:0] dst,
                         input bit brr, input bit brt);
        bit hz, bt;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut;
        ex_mem_read = mr; ex_dest = dst; br_resolve = brr; br_taken = brt;
        hz = v && mr && (dst != 0) && ((dst == rs) || (ut && dst == rt));
        bt = brr && brt;
        #2;
        check_all(hz, bt);
        @(posedge clk);
        model_step(0, hz, bt);
        model_step(1, hz, bt);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all(0, 0);
        chk("reset_pc_write", int'(pc_a), 1);
        chk("reset_busy", int'(busy_a), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use on rs
        cycle(1, 5, 0, 0, 1, 5, 0, 0);
        cycle(1, 5, 0, 0, 0, 5, 0, 0);
        chk("sev_after_rs", int'(sev_a), 1);
        idle(); idle();

        // rt gating and register 0
        cycle(1, 1, 7, 0, 1, 7, 0, 0);
        cycle(1, 1, 7, 1, 1, 7, 0, 0);
        idle(); idle(); idle();
        cycle(1, 0, 3, 1, 1, 0, 0, 0);
        chk("sev_after_rt", int'(sev_a), 2);

        // Taken branch: three squash cycles
        cycle(1, 2, 3, 1, 0, 9, 1, 1);
        idle(); idle();
        chk("fev_after_branch", int'(fev_a), 1);
        chk("busy_after_flush", int'(busy_a), 0);
        idle();

        // Simultaneous hazard and taken branch
        cycle(1, 4, 0, 0, 1, 4, 1, 1);
        idle(); idle();
        chk("sev_sim_unchanged", int'(sev_a), 2);
        chk("fev_sim", int'(fev_a), 2);
        idle();

        // Long stall aborted by a branch in its second cycle (dut_b)
        cycle(1, 6, 0, 0, 1, 6, 0, 0);
        cycle(1, 6, 0, 0, 1, 6, 1, 1);
        idle(); idle(); idle();
        chk("busy_b_after_abort", int'(busy_b), 0);

        // Branch during FLUSH restarts the squash
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        idle(); idle(); idle();

        // Saturation: 20 hazards, dut_b counter is 4 bits wide
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8, 0, 0, 1, 8, 0, 0);
            idle(); idle(); idle();
        end
        chk("sev_b_saturated", int'(sev_b), 15);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0, 1'($urandom));
        end

        // Async reset in the middle of a flush
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        chk("busy_before_reset", int'(busy_a), 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(0, 0);
        chk("reset_flush_drop", int'(fl_a), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        idle();
        cycle(1, 5, 0, 0, 1, 5, 0, 0);
        idle(); idle(); idle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
